mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the next-generation datapath.
- Sits beside the ALU in the execute stage and takes operands from the register-file read ports.
- Models fixed multiply and divide latency through a Busy handshake, so the controller can stall dependent instructions.
- Supports signed and unsigned mult/div plus direct HI/LO writes (MTHI/MTLO).

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  synchronous active-low reset
Start  input  1  operation request, sampled on rising Clk
Op  input  3  operation code (see constants)
A  input  WIDTH  operand rs
B  input  WIDTH  operand rt
Busy  output  1  long operation in flight
Done  output  1  one-cycle pulse when a mult/div result commits
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset: one clock, one reset, no asynchronous paths.
  - Reset==0 at a rising Clk edge clears HI, LO, Busy, Done, the counter and the pending result registers.
  - State goes to IDLE.
  - Reset mid-operation aborts it; no commit and no Done.
- States: IDLE, RUN.
- IDLE with Start=1 and Op in {MULT, MULTU, DIV, DIVU}:
  - The result is computed from A/B sampled at that edge and latched into pending registers (pend_hi, pend_lo).
  - The counter is loaded with the latency for Op; state moves to RUN.
  - Busy=1 from that edge.
- IDLE with Start=1 and Op=MTHI: HI<=A at that edge. Op=MTLO: LO<=A at that edge. No Busy, no Done.
- RUN:
  - The counter decrements each cycle.
  - Busy stays high for exactly N cycles after the Start edge (N = MULT_CYCLES or DIV_CYCLES).
  - At the edge where Busy falls, HI/LO <= pending values, state returns to IDLE, and Done=1 for the following cycle only.
- Start while Busy=1 (any Op, including MTHI/MTLO) is ignored. The controller must stall.
- Start in IDLE on the cycle Done is high is accepted normally, giving back-to-back operation.
- HI/LO outputs hold their old values throughout RUN. There is no early forwarding of pending results.
- Arithmetic:
  - MULT: signed 2*WIDTH product, HI=upper, LO=lower.
  - MULTU: same, unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
- Divide by zero (B==0): LO=all ones, HI=A. Latency and Done are unchanged.
- Signed overflow (A=most negative, B=-1): LO=A, HI=0.
- Invalid Op with Start=1: ignored, no state change.

Decomposition:
- Shared header mdu_defs.vh holds:
  - Op codes: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5.
  - State encodings IDLE=1'b0, RUN=1'b1.
- The controller includes the same header to drive Op.
- One sub-module is natural: mdu_calc. It is purely combinational and maps (Op, A, B) to {hi, lo}, including the divide-by-zero and overflow rules. The sequencing (counter, states, commit) stays in mdu_unit.

Test Plan:
- Reset=0 for 2 cycles, then Reset=1 -> HI=0, LO=0, Busy=0, Done=0.
- MULT with A=32'hFFFFFFFE (-2), B=3, defaults:
  - Busy=1 for exactly 5 cycles; HI/LO unchanged during them.
  - Then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, with a one-cycle Done.
- DIVU A=7, B=2 -> after 10 Busy cycles LO=3, HI=1.
  - Then immediately DIV A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- MTHI A=32'h12345678, then MTLO A=32'h9ABCDEF0 -> each updates on its own edge, Busy stays 0, no Done.
- Edge cases:
  - MULTU A=5, B=5, then MTLO A=1 issued 2 cycles into RUN -> MTLO ignored; final LO=25, HI=0.
  - DIV A=9, B=0 -> LO=32'hFFFFFFFF, HI=9.
  - DIV A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0.
- DIV started, Reset=0 on cycle 4 -> Busy=0, HI/LO=0, no Done.
  - Re-parametrise MULT_CYCLES=1: Busy high one cycle; Done on the next.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// Shared opcodes, state encodings and opcode classification for the multiply/divide unit.
package mdu_unit_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic is_mult(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// Combinational multiply/divide datapath: maps (op, a, b) to the HI/LO pair,
// including the divide-by-zero and signed-overflow results.
module mdu_calc
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   quo_u;
    logic [WIDTH-1:0]   rem_u;
    logic               b_zero;
    logic               s_ovf;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign b_zero = (b == '0);
    assign s_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Raw quotients are only selected when the special cases below do not apply.
    assign quo_s = $signed(a) / $signed(b);
    assign rem_s = $signed(a) % $signed(b);
    assign quo_u = a / b;
    assign rem_u = a % b;

    always_comb begin
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                hi = prod_s[2*WIDTH-1:WIDTH];
                lo = prod_s[WIDTH-1:0];
            end
            OP_MULTU: begin
                hi = prod_u[2*WIDTH-1:WIDTH];
                lo = prod_u[WIDTH-1:0];
            end
            OP_DIV: begin
                if (b_zero) begin
                    hi = a;
                    lo = '1;
                end else if (s_ovf) begin
                    hi = '0;
                    lo = a;
                end else begin
                    hi = rem_s;
                    lo = quo_s;
                end
            end
            OP_DIVU: begin
                if (b_zero) begin
                    hi = a;
                    lo = '1;
                end else begin
                    hi = rem_u;
                    lo = quo_u;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Results are computed at the Start edge and committed after a fixed latency.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [OP_W-1:0]  Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   calc_hi;
    logic [WIDTH-1:0]   calc_lo;

    mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op (Op),
        .a  (A),
        .b  (B),
        .hi (calc_hi),
        .lo (calc_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_mult(Op) || is_div(Op)) begin
                        pend_hi_d = calc_hi;
                        pend_lo_d = calc_lo;
                        cnt_d     = is_mult(Op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d   = RUN;
                    end else if (Op == OP_MTHI) begin
                        hi_d = A;
                    end else if (Op == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                // Commit on the edge that ends the N-th busy cycle.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            done_q    <= done_d;
        end
    end

    assign Busy = (state_q == RUN);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
